fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decode/control stage. It owns the PC, issues one instruction-memory request at a time over a valid/ready request channel, and captures the response into the IF/ID output register. Decode consumes `if_opcode` (instr[6:2]), `if_instr`, `if_pc` and `if_pc_plus4`. Supports decode stall (hold) and branch/jump redirect (flush), with a 1-entry skid buffer for responses that arrive while the output register is held.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, value of `if_instr` when no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  request to instruction memory
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  XLEN  request address; word aligned, [1:0]=0
imem_rsp_valid  in  1  response data valid; no backpressure
imem_rsp_data  in  32  fetched instruction
stall  in  1  decode cannot accept; hold IF/ID register
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored
if_valid  out  1  IF/ID holds a valid instruction
if_instr  out  32  fetched instruction, NOP_INSTR when invalid
if_opcode  out  5  if_instr[6:2], feeds the control unit
if_pc  out  XLEN  address of if_instr
if_pc_plus4  out  XLEN  if_pc+4, link value for JAL/JALR

Behaviour:
- Reset (async on rst_n low):
  - pc=RESET_PC, state=IDLE, skid empty.
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=4.
  - imem_req_valid=0.
- States:
  - IDLE: exits to REQ on the first edge after reset release.
  - REQ: imem_req_valid=1, imem_addr=pc. Issue is suppressed (req_valid=0) while the skid is full.
  - REQ -> WAIT on req_valid && req_ready.
  - WAIT: wait for rsp_valid. Exactly one request is outstanding.
  - DRAIN: a flushed request is outstanding. Discard the next rsp_valid, then go to REQ.
- Response in WAIT (rsp_valid=1):
  - pc <= pc+4 (wraps modulo 2^XLEN); state -> REQ.
  - If the output slot is free (!if_valid || !stall): load if_instr=rsp_data, if_pc=pc, if_pc_plus4=pc+4, if_valid=1.
  - Otherwise: write the response into the skid with its pc.
- Output consumption:
  - An instruction is consumed when if_valid && !stall.
  - On consumption with the skid full: the skid moves to the output, then the skid is emptied.
  - On consumption with the skid empty and no response this cycle: if_valid=0, if_instr=NOP_INSTR.
- Throughput: 2 cycles per instruction with a zero-wait memory (REQ, WAIT).
- Stall: holds if_* unchanged. In-flight responses go to the skid. No new issue while the skid is full.
- Redirect (highest priority, overrides stall):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}; if_valid=0; if_instr=NOP_INSTR; skid cleared.
  - Next state depends on the state at the redirect:
    - WAIT with no rsp this cycle -> DRAIN.
    - WAIT with rsp this cycle -> response discarded, REQ.
    - REQ with handshake this cycle -> DRAIN.
    - REQ without handshake -> REQ. The request address switches next cycle; imem_addr may change while req_valid is high only in this case.
    - DRAIN -> DRAIN. If rsp arrives the same cycle: REQ.
    - IDLE -> IDLE.
- rsp_valid outside WAIT/DRAIN is a protocol error. It is ignored and flagged by a bench assertion.
- Reset asserted mid-request: all state is cleared immediately. Any late response after reset is ignored, because the FSM is in IDLE/REQ.

Decomposition:
- Shared package `riscv_pkg`: XLEN, NOP_INSTR, opcode[6:2] constants (OP_R=5'b01100, OP_I=5'b00100, OP_S=5'b01000, OP_BR=5'b11000, OP_JALR=5'b11001, OP_JAL=5'b11011), and the fetch state enum {IDLE, REQ, WAIT, DRAIN}.
- Sub-module `fetch_skid_buf`: 1-entry instr+pc buffer with push/pop/clear and a full flag.

Test Plan:
- Reset release, ready=1, rsp 1 cycle after accept with data 0x00500093 -> imem_addr=0x0, then if_valid=1, if_instr=0x00500093, if_opcode=5'b00100, if_pc=0, if_pc_plus4=4; next request to 0x4.
- Stream of 4 instructions with stall=0 -> addresses 0,4,8,C; one if_valid pulse per 2 cycles; pcs match.
- Stall asserted while a rsp to 0x8 is in flight -> if_* holds the 0x4 instruction, 0x8 enters the skid, no request issued; stall released -> 0x8 appears the next cycle, then a fetch of 0xC.
- redirect_valid with redirect_pc=0x103 in WAIT -> next rsp discarded (DRAIN), next request to 0x100, if_valid=0 until the 0x100 response arrives.
- Redirect in the same cycle as stall and a full skid -> skid and output flushed, if_instr=NOP_INSTR, fetch resumes at the target.
- rst_n pulsed low while in WAIT -> outputs at reset values asynchronously; the late rsp is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Constants shared by the RV32 fetch and decode stages, plus the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // instr[6:2] major opcodes consumed by the control unit
  localparam logic [4:0] OP_R    = 5'b01100;
  localparam logic [4:0] OP_I    = 5'b00100;
  localparam logic [4:0] OP_S    = 5'b01000;
  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [4:0] OP_JAL  = 5'b11011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched instruction and its pc while decode is stalled.
module fetch_skid_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [31:0]     push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic            full,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);
  import riscv_pkg::*;

  // clear (redirect) beats push; push and pop never coincide since a push only
  // happens while the output register is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full  <= 1'b1;
      instr <= push_instr;
      pc    <= push_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, issues one imem request at a time and fills the IF/ID register.
//   state | meaning
//   IDLE  | just out of reset, no request yet
//   REQ   | presenting pc on the request channel (held off while the skid is full)
//   WAIT  | one request outstanding, response will be kept
//   DRAIN | one flushed request outstanding, its response is dropped
module fetch_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [4:0]      if_opcode,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);
  import riscv_pkg::*;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            req_fire;
  logic            rsp_take;
  logic            consume;
  logic            slot_free;
  logic            skid_push;
  logic            skid_pop;
  logic            skid_full;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  assign imem_req_valid = (state == REQ) && !skid_full;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = (state == WAIT) && imem_rsp_valid;
  assign consume        = if_valid && !stall;
  assign slot_free      = !if_valid || !stall;
  assign pc_plus4       = pc + PC_STEP;
  assign skid_push      = rsp_take && !slot_free && !redirect_valid;
  assign skid_pop       = consume && skid_full && !rsp_take && !redirect_valid;
  assign if_opcode      = if_instr[6:2];

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (skid_push),
    .pop        (skid_pop),
    .clear      (redirect_valid),
    .push_instr (imem_rsp_data),
    .push_pc    (pc),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC & ALIGN_MASK;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= '0;
      if_pc_plus4 <= PC_STEP;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ALIGN_MASK;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      // a request already on its way must be drained before refetching
      case (state)
        IDLE:    state <= IDLE;
        REQ:     state <= req_fire ? DRAIN : REQ;
        WAIT:    state <= imem_rsp_valid ? REQ : DRAIN;
        DRAIN:   state <= imem_rsp_valid ? REQ : DRAIN;
        default: state <= IDLE;
      endcase
    end else begin
      if (rsp_take && slot_free) begin
        if_valid    <= 1'b1;
        if_instr    <= imem_rsp_data;
        if_pc       <= pc;
        if_pc_plus4 <= pc_plus4;
      end else if (consume) begin
        if (skid_full) begin
          if_valid    <= 1'b1;
          if_instr    <= skid_instr;
          if_pc       <= skid_pc;
          if_pc_plus4 <= skid_pc + PC_STEP;
        end else begin
          if_valid <= 1'b0;
          if_instr <= NOP_INSTR;
        end
      end

      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (req_fire) state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state <= REQ;
            pc    <= pc_plus4;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by a randomized run scored against an in-order pc-stream model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [4:0]  if_opcode;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int          vectors = 0;
  int          miscompares = 0;
  int          consumed = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_if_instr"}, if_instr, NOP);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd4);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
  endtask

  // entered just after an edge with the FSM presenting a request for a; stall must be low
  task automatic fetch_one(input logic [31:0] a);
    logic [31:0] d;
    d = memf(a);
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, a);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_if_valid", {31'd0, if_valid}, 32'd0);
    chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    step();
    imem_rsp_valid = 1'b0;
    chk("if_valid", {31'd0, if_valid}, 32'd1);
    chk("if_pc", if_pc, a);
    chk("if_instr", if_instr, d);
    chk("if_opcode", {27'd0, if_opcode}, {27'd0, d[6:2]});
    chk("if_pc_plus4", if_pc_plus4, a + 32'd4);
  endtask

  // scoreboard monitor: every consumed instruction must be the next one of the pc stream
  always @(negedge clk) begin
    if (mon_en) begin
      if (!if_valid) begin
        chk("idle_nop", if_instr, NOP);
      end else if (!stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          logic [31:0] e;
          logic [31:0] d;
          e = exp_q.pop_front();
          d = memf(e);
          chk("sb_pc", if_pc, e);
          chk("sb_instr", if_instr, d);
          chk("sb_opcode", {27'd0, if_opcode}, {27'd0, d[6:2]});
          chk("sb_pc_plus4", if_pc_plus4, e + 32'd4);
          consumed++;
        end
      end
    end
  end

  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          lat;

    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // reset state, then first fetch with a 1-cycle memory
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_addr, 32'd0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("first_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    step();
    imem_rsp_valid = 1'b0;
    chk("first_if_valid", {31'd0, if_valid}, 32'd1);
    chk("first_if_instr", if_instr, 32'h0050_0093);
    chk("first_if_opcode", {27'd0, if_opcode}, 32'd4);
    chk("first_if_pc", if_pc, 32'd0);
    chk("first_if_pc_plus4", if_pc_plus4, 32'd4);

    // streaming fetches
    for (int i = 1; i < 5; i++) fetch_one(32'(i * 4));

    // stall with a response in flight: it parks in the skid and issue stops
    stall = 1'b1;
    chk("stall_req_addr", imem_addr, 32'h14);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("stall_hold_pc", if_pc, 32'h10);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = memf(32'h14);
    step();
    imem_rsp_valid = 1'b0;
    chk("stall_hold_pc2", if_pc, 32'h10);
    chk("stall_hold_instr", if_instr, memf(32'h10));
    chk("skid_full_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    chk("skid_full_no_req2", {31'd0, imem_req_valid}, 32'd0);
    stall = 1'b0;
    step();
    chk("skid_out_valid", {31'd0, if_valid}, 32'd1);
    chk("skid_out_pc", if_pc, 32'h14);
    chk("skid_out_instr", if_instr, memf(32'h14));
    chk("skid_out_plus4", if_pc_plus4, 32'h18);
    chk("after_skid_req", {31'd0, imem_req_valid}, 32'd1);
    chk("after_skid_addr", imem_addr, 32'h18);

    // redirect while waiting: stale response dropped, refetch from aligned target
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    chk("drain_if_valid", {31'd0, if_valid}, 32'd0);
    chk("drain_if_instr", if_instr, NOP);
    chk("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = memf(32'h18);
    step();
    imem_rsp_valid = 1'b0;
    chk("drained_if_valid", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h100);

    // redirect together with stall and a full skid
    stall = 1'b1;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = memf(32'h104);
    step();
    imem_rsp_valid = 1'b0;
    chk("skid2_no_req", {31'd0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    chk("flush_if_valid", {31'd0, if_valid}, 32'd0);
    chk("flush_if_instr", if_instr, NOP);
    chk("flush_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("flush_req_addr", imem_addr, 32'h200);
    fetch_one(32'h200);

    // asynchronous reset in WAIT, late response ignored
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    chk("late_rsp_if_valid", {31'd0, if_valid}, 32'd0);
    chk("late_rsp_if_instr", if_instr, NOP);
    fetch_one(32'h0);

    // randomized run: memory with random ready/latency, random stall and redirects
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    pend           = 1'b0;
    pend_addr      = '0;
    lat            = 0;
    exp_q.delete();
    next_pc = 32'h0;
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_pc);
      next_pc += 32'd4;
    end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memf(pend_addr);
          pend           = 1'b0;
        end else begin
          lat--;
        end
      end
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      if (redirect_valid) begin
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
        exp_q.delete();
        next_pc = redirect_pc & ~32'd3;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back(next_pc);
        next_pc += 32'd4;
      end
      imem_req_ready = $urandom_range(0, 1) == 1;
      if (imem_req_valid && imem_req_ready) begin
        chk("single_outstanding", {31'd0, pend}, 32'd0);
        chk("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
        pend      = 1'b1;
        pend_addr = imem_addr;
        lat       = $urandom_range(0, 2);
      end
      step();
    end
    mon_en         = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("forward_progress", {31'd0, consumed >= 200}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
